// File: rtl/wb_stage_flush_ctl.sv
// ============================================================================
// Module   : wb_stage_flush_ctl
// Brief    : LoongArch writeback stage with exception/ertn commit, timed
//            flush window and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_flush_ctl #(
  parameter int XLEN         = 32,
  parameter int RA_W         = 5,
  parameter int EXC_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32,
  localparam int EXC_CW      = (EXC_W > 1) ? $clog2(EXC_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // MEM -> WB handshake and payload
  input  logic              i_mem_to_wb_valid,
  output logic              o_wb_allowin,
  input  logic [XLEN-1:0]   i_mem_pc,
  input  logic              i_mem_rf_we,
  input  logic [RA_W-1:0]   i_mem_rf_waddr,
  input  logic [XLEN-1:0]   i_mem_rf_wdata,
  input  logic              i_mem_csr_rd,
  input  logic              i_mem_csr_we,
  input  logic [13:0]       i_mem_csr_num,
  input  logic [XLEN-1:0]   i_mem_csr_wmask,
  input  logic [XLEN-1:0]   i_mem_csr_wvalue,
  input  logic [EXC_W-1:0]  i_mem_exc,
  input  logic              i_mem_ertn,
  input  logic [XLEN-1:0]   i_csr_rvalue,
  // register file write port (also feeds ID bypass)
  output logic              o_rf_we,
  output logic [RA_W-1:0]   o_rf_waddr,
  output logic [XLEN-1:0]   o_rf_wdata,
  // CSR port
  output logic              o_csr_we,
  output logic [13:0]       o_csr_num,
  output logic [XLEN-1:0]   o_csr_wmask,
  output logic [XLEN-1:0]   o_csr_wvalue,
  // commit events
  output logic              o_exc_valid,
  output logic [EXC_CW-1:0] o_exc_code,
  output logic [XLEN-1:0]   o_exc_pc,
  output logic              o_ertn_flush,
  output logic              o_flush,
  output logic [CNT_W-1:0]  o_retire_cnt,
  // trace port
  output logic [XLEN-1:0]   o_debug_wb_pc,
  output logic [3:0]        o_debug_wb_rf_we,
  output logic [RA_W-1:0]   o_debug_wb_rf_wnum,
  output logic [XLEN-1:0]   o_debug_wb_rf_wdata
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FC_W-1:0]     r_fcnt;
  logic [FC_W-1:0]     w_fcnt_nxt;

  logic                r_wb_valid;
  logic [XLEN-1:0]     r_pc;
  logic                r_rf_we;
  logic [RA_W-1:0]     r_rf_waddr;
  logic [XLEN-1:0]     r_rf_wdata;
  logic                r_csr_rd;
  logic                r_csr_we;
  logic [13:0]         r_csr_num;
  logic [XLEN-1:0]     r_csr_wmask;
  logic [XLEN-1:0]     r_csr_wvalue;
  logic [EXC_W-1:0]    r_exc;
  logic                r_ertn;
  logic [CNT_W-1:0]    r_retire_cnt;

  logic                w_ready_go;
  logic                w_allowin;
  logic                w_load;
  logic                w_exc_any;
  logic                w_commit;
  logic                w_flush;
  logic                w_retire;
  logic                w_rf_we;
  logic [XLEN-1:0]     w_rf_wdata;
  logic [EXC_CW-1:0]   w_exc_code;

  assign w_ready_go = 1'b1;
  assign w_allowin  = ~r_wb_valid | w_ready_go;
  assign w_load     = i_mem_to_wb_valid & w_allowin;

  assign w_exc_any  = |r_exc;
  assign w_commit   = r_wb_valid & (w_exc_any | r_ertn);
  assign w_flush    = w_commit | (r_state == ST_FLUSH);
  assign w_retire   = r_wb_valid & ~w_exc_any;

  // Payload is latched even when the op is being dropped; only valid is gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid   <= 1'b0;
      r_pc         <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_csr_rd     <= 1'b0;
      r_csr_we     <= 1'b0;
      r_csr_num    <= '0;
      r_csr_wmask  <= '0;
      r_csr_wvalue <= '0;
      r_exc        <= '0;
      r_ertn       <= 1'b0;
    end else begin
      r_wb_valid <= w_load & ~w_flush;
      if (w_load) begin
        r_pc         <= i_mem_pc;
        r_rf_we      <= i_mem_rf_we;
        r_rf_waddr   <= i_mem_rf_waddr;
        r_rf_wdata   <= i_mem_rf_wdata;
        r_csr_rd     <= i_mem_csr_rd;
        r_csr_we     <= i_mem_csr_we;
        r_csr_num    <= i_mem_csr_num;
        r_csr_wmask  <= i_mem_csr_wmask;
        r_csr_wvalue <= i_mem_csr_wvalue;
        r_exc        <= i_mem_exc;
        r_ertn       <= i_mem_ertn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Flush window: FLUSH_CYCLES cycles in FLUSH after the commit cycle itself.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (w_commit) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FC_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (r_fcnt <= FC_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = '0;
        end else begin
          w_fcnt_nxt  = r_fcnt - FC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  // Lowest-numbered cause has highest priority.
  always_comb begin
    w_exc_code = '0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (r_exc[i]) begin
        w_exc_code = EXC_CW'(i);
      end
    end
  end

  assign w_rf_we    = r_wb_valid & r_rf_we & ~w_commit;
  assign w_rf_wdata = r_csr_rd ? i_csr_rvalue : r_rf_wdata;

  assign o_wb_allowin        = w_allowin;
  assign o_rf_we             = w_rf_we;
  assign o_rf_waddr          = r_rf_waddr;
  assign o_rf_wdata          = w_rf_wdata;
  assign o_csr_we            = r_wb_valid & r_csr_we & ~w_commit;
  assign o_csr_num           = r_csr_num;
  assign o_csr_wmask         = r_csr_wmask;
  assign o_csr_wvalue        = r_csr_wvalue;
  assign o_exc_valid         = r_wb_valid & w_exc_any;
  assign o_exc_code          = w_exc_code;
  assign o_exc_pc            = r_pc;
  assign o_ertn_flush        = r_wb_valid & r_ertn & ~w_exc_any;
  assign o_flush             = w_flush;
  assign o_retire_cnt        = r_retire_cnt;
  assign o_debug_wb_pc       = r_pc;
  assign o_debug_wb_rf_we    = {4{w_rf_we}};
  assign o_debug_wb_rf_wnum  = r_rf_waddr;
  assign o_debug_wb_rf_wdata = w_rf_wdata;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_flush_ctl.sv
// ============================================================================
// Module   : tb_wb_stage_flush_ctl
// Brief    : Self-checking bench for wb_stage_flush_ctl (32-bit and 4-bit
//            retire counter instances share one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_flush_ctl;

  localparam int FLUSH_CYCLES = 2;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_rd;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [4:0]  exc;
    logic        ertn;
    logic [31:0] rvalue;
  } op_t;

  typedef struct {
    op_t         op;
    logic        e_rf_we;
    logic [31:0] e_wdata;
    logic        e_csr_we;
    logic        e_exc;
    logic [2:0]  e_code;
    logic        e_ertn;
    logic        e_flush;
    logic [31:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_v, i_rf_we, i_csr_rd, i_csr_we, i_ertn;
  logic [31:0] i_pc, i_wdata, i_wmask, i_wvalue, i_rvalue;
  logic [4:0]  i_waddr, i_exc;
  logic [13:0] i_csr_num;

  logic        o_allowin, o_rf_we, o_csr_we, o_exc_valid, o_ertn_flush, o_flush;
  logic [4:0]  o_rf_waddr, o_dbg_wnum;
  logic [31:0] o_rf_wdata, o_csr_wmask, o_csr_wvalue, o_exc_pc, o_retire_cnt;
  logic [31:0] o_dbg_pc, o_dbg_wdata;
  logic [13:0] o_csr_num;
  logic [2:0]  o_exc_code;
  logic [3:0]  o_dbg_we;

  logic        d4_allowin, d4_rf_we, d4_csr_we, d4_exc_valid, d4_ertn_flush, d4_flush;
  logic [4:0]  d4_rf_waddr, d4_dbg_wnum;
  logic [31:0] d4_rf_wdata, d4_csr_wmask, d4_csr_wvalue, d4_exc_pc, d4_dbg_pc, d4_dbg_wdata;
  logic [13:0] d4_csr_num;
  logic [2:0]  d4_exc_code;
  logic [3:0]  d4_dbg_we, d4_retire_cnt;

  wb_stage_flush_ctl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_to_wb_valid(i_v), .o_wb_allowin(o_allowin), .i_mem_pc(i_pc),
    .i_mem_rf_we(i_rf_we), .i_mem_rf_waddr(i_waddr), .i_mem_rf_wdata(i_wdata),
    .i_mem_csr_rd(i_csr_rd), .i_mem_csr_we(i_csr_we), .i_mem_csr_num(i_csr_num),
    .i_mem_csr_wmask(i_wmask), .i_mem_csr_wvalue(i_wvalue), .i_mem_exc(i_exc),
    .i_mem_ertn(i_ertn), .i_csr_rvalue(i_rvalue),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_csr_we(o_csr_we), .o_csr_num(o_csr_num), .o_csr_wmask(o_csr_wmask),
    .o_csr_wvalue(o_csr_wvalue), .o_exc_valid(o_exc_valid), .o_exc_code(o_exc_code),
    .o_exc_pc(o_exc_pc), .o_ertn_flush(o_ertn_flush), .o_flush(o_flush),
    .o_retire_cnt(o_retire_cnt), .o_debug_wb_pc(o_dbg_pc), .o_debug_wb_rf_we(o_dbg_we),
    .o_debug_wb_rf_wnum(o_dbg_wnum), .o_debug_wb_rf_wdata(o_dbg_wdata)
  );

  wb_stage_flush_ctl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_mem_to_wb_valid(i_v), .o_wb_allowin(d4_allowin), .i_mem_pc(i_pc),
    .i_mem_rf_we(i_rf_we), .i_mem_rf_waddr(i_waddr), .i_mem_rf_wdata(i_wdata),
    .i_mem_csr_rd(i_csr_rd), .i_mem_csr_we(i_csr_we), .i_mem_csr_num(i_csr_num),
    .i_mem_csr_wmask(i_wmask), .i_mem_csr_wvalue(i_wvalue), .i_mem_exc(i_exc),
    .i_mem_ertn(i_ertn), .i_csr_rvalue(i_rvalue),
    .o_rf_we(d4_rf_we), .o_rf_waddr(d4_rf_waddr), .o_rf_wdata(d4_rf_wdata),
    .o_csr_we(d4_csr_we), .o_csr_num(d4_csr_num), .o_csr_wmask(d4_csr_wmask),
    .o_csr_wvalue(d4_csr_wvalue), .o_exc_valid(d4_exc_valid), .o_exc_code(d4_exc_code),
    .o_exc_pc(d4_exc_pc), .o_ertn_flush(d4_ertn_flush), .o_flush(d4_flush),
    .o_retire_cnt(d4_retire_cnt), .o_debug_wb_pc(d4_dbg_pc), .o_debug_wb_rf_we(d4_dbg_we),
    .o_debug_wb_rf_wnum(d4_dbg_wnum), .o_debug_wb_rf_wdata(d4_dbg_wdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the op sitting in WB, remaining flush cycles, retire total.
  op_t         cur;
  op_t         m_p;
  logic        m_valid;
  int          m_left;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic op_t mk_op(input logic v, input logic [31:0] pc, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd);
    op_t o;
    o.v = v; o.pc = pc; o.rf_we = we; o.waddr = wa; o.wdata = wd;
    o.csr_rd = 1'b0; o.csr_we = 1'b0; o.csr_num = '0; o.wmask = '0; o.wvalue = '0;
    o.exc = '0; o.ertn = 1'b0; o.rvalue = '0;
    return o;
  endfunction

  function automatic vec_t mk_vec(input op_t o, input logic rfwe, input logic [31:0] wd,
                                  input logic cwe, input logic ex, input logic [2:0] code,
                                  input logic er, input logic fl, input logic [31:0] cnt);
    vec_t r;
    r.op = o; r.e_rf_we = rfwe; r.e_wdata = wd; r.e_csr_we = cwe; r.e_exc = ex;
    r.e_code = code; r.e_ertn = er; r.e_flush = fl; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic drive(input op_t o);
    cur = o;
    i_v = o.v; i_pc = o.pc; i_rf_we = o.rf_we; i_waddr = o.waddr; i_wdata = o.wdata;
    i_csr_rd = o.csr_rd; i_csr_we = o.csr_we; i_csr_num = o.csr_num;
    i_wmask = o.wmask; i_wvalue = o.wvalue; i_exc = o.exc; i_ertn = o.ertn;
    i_rvalue = o.rvalue;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_left = 0; m_cnt = '0;
    m_p = mk_op(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic model_check();
    logic       exc_any, commit, e_we;
    logic [2:0] code;
    logic [31:0] wd;
    exc_any = |m_p.exc;
    commit  = m_valid && (exc_any || m_p.ertn);
    e_we    = m_valid && m_p.rf_we && !commit;
    wd      = m_p.csr_rd ? cur.rvalue : m_p.wdata;
    code    = '0;
    for (int i = 4; i >= 0; i--) if (m_p.exc[i]) code = 3'(i);
    chk("allowin",    {63'd0, o_allowin},    64'd1);
    chk("rf_we",      {63'd0, o_rf_we},      {63'd0, e_we});
    chk("rf_waddr",   {59'd0, o_rf_waddr},   {59'd0, m_p.waddr});
    chk("rf_wdata",   {32'd0, o_rf_wdata},   {32'd0, wd});
    chk("csr_we",     {63'd0, o_csr_we},     {63'd0, m_valid && m_p.csr_we && !commit});
    chk("csr_port",   {o_csr_num, o_csr_wmask, 18'd0}, {m_p.csr_num, m_p.wmask, 18'd0});
    chk("csr_wvalue", {32'd0, o_csr_wvalue}, {32'd0, m_p.wvalue});
    chk("exc_valid",  {63'd0, o_exc_valid},  {63'd0, m_valid && exc_any});
    chk("exc_code",   {61'd0, o_exc_code},   {61'd0, code});
    chk("exc_pc",     {32'd0, o_exc_pc},     {32'd0, m_p.pc});
    chk("ertn_flush", {63'd0, o_ertn_flush}, {63'd0, m_valid && m_p.ertn && !exc_any});
    chk("flush",      {63'd0, o_flush},      {63'd0, commit || (m_left > 0)});
    chk("retire_cnt", {32'd0, o_retire_cnt}, {32'd0, m_cnt});
    chk("retire_cnt4",{60'd0, d4_retire_cnt},{60'd0, m_cnt[3:0]});
    chk("debug",      {o_dbg_pc, o_dbg_we, o_dbg_wnum, 23'd0},
                      {m_p.pc, {4{e_we}}, m_p.waddr, 23'd0});
    chk("debug_wdata",{32'd0, o_dbg_wdata},  {32'd0, wd});
  endtask

  task automatic model_update();
    logic commit, fl;
    commit = m_valid && ((|m_p.exc) || m_p.ertn);
    fl     = commit || (m_left > 0);
    if (m_valid && !(|m_p.exc)) m_cnt = m_cnt + 32'd1;
    if (m_left > 0) m_left = m_left - 1;
    else if (commit) m_left = FLUSH_CYCLES;
    m_valid = cur.v && !fl;
    if (cur.v) m_p = cur;
  endtask

  task automatic step_a(input op_t o);
    @(negedge clk);
    drive(o);
    #1;
    model_check();
  endtask

  task automatic step_b();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input op_t o);
    step_a(o);
    step_b();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk_op(1'b0, '0, 1'b0, '0, '0));
    model_reset();
    #1;
    model_check();
    chk("rst_flush", {63'd0, o_flush}, 64'd0);
    chk("rst_cnt",   {32'd0, o_retire_cnt}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[17];
  op_t  t;
  op_t  idle;

  initial begin
    idle = mk_op(1'b0, '0, 1'b0, '0, '0);
    drive(idle);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Directed table: expectations reflect the op presented on the previous row.
    tbl[0] = mk_vec(mk_op(1, 32'h100, 1, 5'd3, 32'h11), 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk_vec(mk_op(1, 32'h104, 1, 5'd4, 32'h22), 1, 32'h11, 0, 0, 0, 0, 0, 0);
    t = mk_op(1, 32'h108, 1, 5'd5, 32'h0); t.csr_rd = 1; t.csr_num = 14'h5; t.rvalue = 32'hDEAD;
    tbl[2] = mk_vec(t, 1, 32'h22, 0, 0, 0, 0, 0, 1);
    t = mk_op(1, 32'h10C, 0, 5'd0, 32'h0); t.csr_we = 1; t.csr_num = 14'h6;
    t.wmask = 32'hFF; t.wvalue = 32'h5A; t.rvalue = 32'hDEAD;
    tbl[3] = mk_vec(t, 1, 32'hDEAD, 0, 0, 0, 0, 0, 2);
    t = mk_op(1, 32'h110, 1, 5'd6, 32'h77); t.exc = 5'b01100;
    tbl[4] = mk_vec(t, 0, 0, 1, 0, 0, 0, 0, 3);
    tbl[5] = mk_vec(mk_op(1, 32'h114, 1, 5'd7, 32'h99), 0, 0, 0, 1, 3'd2, 0, 1, 4);
    tbl[6] = mk_vec(mk_op(1, 32'h118, 1, 5'd8, 32'h88), 0, 0, 0, 0, 0, 0, 1, 4);
    tbl[7] = mk_vec(mk_op(1, 32'h11C, 1, 5'd9, 32'hAB), 0, 0, 0, 0, 0, 0, 1, 4);
    t = mk_op(1, 32'h120, 0, 5'd0, 32'h0); t.ertn = 1; t.exc = 5'b00001;
    tbl[8]  = mk_vec(t, 0, 0, 0, 0, 0, 0, 0, 4);
    tbl[9]  = mk_vec(idle, 0, 0, 0, 1, 3'd0, 0, 1, 4);
    tbl[10] = mk_vec(idle, 0, 0, 0, 0, 0, 0, 1, 4);
    tbl[11] = mk_vec(idle, 0, 0, 0, 0, 0, 0, 1, 4);
    t = mk_op(1, 32'h200, 0, 5'd0, 32'h0); t.ertn = 1;
    tbl[12] = mk_vec(t, 0, 0, 0, 0, 0, 0, 0, 4);
    tbl[13] = mk_vec(idle, 0, 0, 0, 0, 0, 1, 1, 4);
    tbl[14] = mk_vec(idle, 0, 0, 0, 0, 0, 0, 1, 5);
    tbl[15] = mk_vec(idle, 0, 0, 0, 0, 0, 0, 1, 5);
    tbl[16] = mk_vec(idle, 0, 0, 0, 0, 0, 0, 0, 5);

    for (int r = 0; r < 17; r++) begin
      step_a(tbl[r].op);
      chk($sformatf("tbl%0d.rf_we", r),      {63'd0, o_rf_we},      {63'd0, tbl[r].e_rf_we});
      if (tbl[r].e_rf_we)
        chk($sformatf("tbl%0d.rf_wdata", r), {32'd0, o_rf_wdata},   {32'd0, tbl[r].e_wdata});
      chk($sformatf("tbl%0d.csr_we", r),     {63'd0, o_csr_we},     {63'd0, tbl[r].e_csr_we});
      chk($sformatf("tbl%0d.exc_valid", r),  {63'd0, o_exc_valid},  {63'd0, tbl[r].e_exc});
      if (tbl[r].e_exc)
        chk($sformatf("tbl%0d.exc_code", r), {61'd0, o_exc_code},   {61'd0, tbl[r].e_code});
      chk($sformatf("tbl%0d.ertn_flush", r), {63'd0, o_ertn_flush}, {63'd0, tbl[r].e_ertn});
      chk($sformatf("tbl%0d.flush", r),      {63'd0, o_flush},      {63'd0, tbl[r].e_flush});
      chk($sformatf("tbl%0d.retire_cnt", r), {32'd0, o_retire_cnt}, {32'd0, tbl[r].e_cnt});
      step_b();
    end

    // Reset asserted while the flush window is open.
    t = mk_op(1, 32'h300, 1, 5'd1, 32'h1); t.exc = 5'b10000;
    step(t);
    step(idle);
    chk("pre_rst_exc_code", {61'd0, o_exc_code}, 64'd4);
    step(idle);
    chk("pre_rst_flush", {63'd0, o_flush}, 64'd1);
    do_reset();

    // 4-bit counter wrap after 16 retires.
    for (int k = 0; k < 16; k++) step(mk_op(1, 32'h400 + 32'(k * 4), 1, 5'(k), 32'(k)));
    step_a(idle);
    chk("wrap_pre",  {60'd0, d4_retire_cnt}, 64'hF);
    step_b();
    step_a(idle);
    chk("wrap_zero", {60'd0, d4_retire_cnt}, 64'h0);
    chk("wrap_cnt32", {32'd0, o_retire_cnt}, 64'd16);
    step_b();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        t = mk_op(($urandom_range(0, 9) < 7), $urandom, $urandom_range(0, 1) == 1,
                  5'($urandom), $urandom);
        t.csr_rd  = ($urandom_range(0, 3) == 0);
        t.csr_we  = ($urandom_range(0, 3) == 0);
        t.csr_num = 14'($urandom);
        t.wmask   = $urandom;
        t.wvalue  = $urandom;
        t.exc     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
        t.ertn    = ($urandom_range(0, 9) == 0);
        t.rvalue  = $urandom;
        step(t);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
